xm_uart_tx: RTL and testbench

- Byte-wide UART transmitter, 8N1 framing, LSB first, with a runtime-selectable baud rate.
- Sits between a byte producer (CPU/FSM) and the RS-232 TX pin.
- Accepts one byte per single-cycle send_en strobe, signals busy on uart_state, and pulses tx_done when the stop bit completes.

---
 rtl/xm_uart_pkg.sv | 43 ++++
 rtl/xm_uart_baud_gen.sv | 30 +++
 rtl/xm_uart_tx.sv | 133 +++++++++++++
 tb/tb_xm_uart_tx.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/xm_uart_pkg.sv
// Shared UART types, frame constants and baud divisor helper.
// Optional parity via XM_UART_TX_PARITY_EN (adds even parity bit).
package xm_uart_pkg;

  typedef enum logic [2:0] {
    BAUD_9600   = 3'd0,
    BAUD_19200  = 3'd1,
    BAUD_38400  = 3'd2,
    BAUD_57600  = 3'd3,
    BAUD_115200 = 3'd4
  } baud_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

`ifdef XM_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  // Clocks per bit, rounded to nearest; reserved codes map to 115200.
  function automatic int unsigned baud_div(
    input int unsigned clk_freq,
    input logic [2:0]  sel
  );
    int unsigned rate;
    case (baud_e'(sel))
      BAUD_9600:  rate = 9600;
      BAUD_19200: rate = 19200;
      BAUD_38400: rate = 38400;
      BAUD_57600: rate = 57600;
      default:    rate = 115200;
    endcase
    return (clk_freq + rate / 2) / rate;
  endfunction

endpackage

// File: rtl/xm_uart_baud_gen.sv
// Bit-period divider: counts 0..div_i-1 while en_i, ticks on last count.
// Ports: clk, rst_n, en_i, div_i (clocks per bit), bit_tick_o.
import xm_uart_pkg::*;

module xm_uart_baud_gen #(
  parameter int DIV_W = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             bit_tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign bit_tick_o = en_i && (cnt_q == div_i - 1'b1);

  // Held at zero while disabled so each enable starts a full period.
  always_comb begin
    cnt_d = '0;
    if (en_i && !bit_tick_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/xm_uart_tx.sv
// UART transmitter, 8N1 LSB first, runtime baud (XM_UART_TX_PARITY_EN: 8E1).
// Ports: clk, rst (async low), baud_set, data_byte, send_en -> rs232_tx, tx_done, uart_state.
import xm_uart_pkg::*;

module xm_uart_tx #(
  parameter int CLK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] baud_set,
  input  logic [7:0] data_byte,
  input  logic       send_en,
  output logic       rs232_tx,
  output logic       tx_done,
  output logic       uart_state
);

  localparam int DIV_W = $clog2(CLK_FREQ / 9600 + 2);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  state_e           state_q, state_d;
  logic [3:0]       bit_q, bit_d;
  logic [7:0]       data_q, data_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             bit_tick;
  logic             last_bit;

  // Divisors are constant-folded per code; no runtime divider.
  function automatic logic [DIV_W-1:0] div_of(input logic [2:0] sel);
    logic [DIV_W-1:0] d;
    case (sel)
      3'd0:    d = DIV_W'(baud_div(CLK_FREQ, 3'd0));
      3'd1:    d = DIV_W'(baud_div(CLK_FREQ, 3'd1));
      3'd2:    d = DIV_W'(baud_div(CLK_FREQ, 3'd2));
      3'd3:    d = DIV_W'(baud_div(CLK_FREQ, 3'd3));
      default: d = DIV_W'(baud_div(CLK_FREQ, 3'd4));
    endcase
    return d;
  endfunction

  function automatic logic bit_val(
    input logic [3:0] idx,
    input logic [7:0] d
  );
    logic v;
    v = STOP_BIT;
    if (idx == 4'd0)       v = START_BIT;
    else if (idx <= 4'd8)  v = d[3'(idx - 4'd1)];
`ifdef XM_UART_TX_PARITY_EN
    else if (idx == 4'd9)  v = ^d;
`endif
    return v;
  endfunction

  xm_uart_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud (
    .clk        (clk),
    .rst_n      (rst),
    .en_i       (state_q == S_SEND),
    .div_i      (div_q),
    .bit_tick_o (bit_tick)
  );

  assign last_bit = (bit_q == LAST_BIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      data_q  <= '0;
      div_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      div_q   <= div_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (send_en) state_d = S_SEND;
      S_SEND: if (bit_tick && last_bit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Line value is registered one bit ahead so it changes on the tick edge.
  always_comb begin
    bit_d  = bit_q;
    data_d = data_q;
    div_d  = div_q;
    tx_d   = tx_q;
    done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d = STOP_BIT;
        if (send_en) begin
          data_d = data_byte;
          div_d  = div_of(baud_set);
          bit_d  = '0;
          tx_d   = START_BIT;
        end
      end
      S_SEND: begin
        if (bit_tick) begin
          if (last_bit) begin
            bit_d  = '0;
            tx_d   = STOP_BIT;
            done_d = 1'b1;
          end else begin
            bit_d = bit_q + 4'd1;
            tx_d  = bit_val(bit_q + 4'd1, data_q);
          end
        end
      end
      default: ;
    endcase
  end

  assign rs232_tx   = tx_q;
  assign tx_done    = done_q;
  assign uart_state = (state_q == S_SEND);

endmodule

// File: tb/tb_xm_uart_tx.sv
// Directed self-checking bench for xm_uart_tx (default 8N1 build).
// Samples 1 time unit after each rising edge.
module tb_xm_uart_tx;

  logic       clk;
  logic       rst;
  logic [2:0] baud_set;
  logic [7:0] data_byte;
  logic       send_en;
  logic       rs232_tx;
  logic       tx_done;
  logic       uart_state;

  int checks = 0;
  int errors = 0;

  xm_uart_tx #(
    .CLK_FREQ (50000000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_set   (baud_set),
    .data_byte  (data_byte),
    .send_en    (send_en),
    .rs232_tx   (rs232_tx),
    .tx_done    (tx_done),
    .uart_state (uart_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n idle cycles: line high, not busy, no done pulse.
  task automatic idle(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (rs232_tx !== 1'b1 || uart_state !== 1'b0
          || tx_done !== 1'b0) bad++;
    end
    chk(tag, bad, 0);
  endtask

  // Called 1 unit after an edge; strobe is sampled by the next edge.
  task automatic start(input logic [7:0] b, input logic [2:0] s);
    data_byte = b;
    baud_set  = s;
    send_en   = 1'b1;
    step();
    send_en   = 1'b0;
  endtask

  // Checks 10*n cycles of frame, then the tx_done cycle.
  // inj_at >= 0 pulses send_en with other data/baud at that cycle.
  task automatic watch(
    input string      tag,
    input logic [7:0] b,
    input int         n,
    input int         inj_at
  );
    logic [9:0] fr;
    int bad_line, bad_busy, bad_done;
    fr = {1'b1, b, 1'b0};
    bad_line = 0;
    bad_busy = 0;
    bad_done = 0;
    for (int c = 0; c < 10 * n; c++) begin
      if (rs232_tx !== fr[c / n]) bad_line++;
      if (uart_state !== 1'b1)    bad_busy++;
      if (tx_done !== 1'b0)       bad_done++;
      if (inj_at >= 0 && c == inj_at) begin
        data_byte = ~b;
        baud_set  = 3'd4;
        send_en   = 1'b1;
      end
      if (inj_at >= 0 && c == inj_at + 1) send_en = 1'b0;
      step();
    end
    chk({tag, "_line"}, bad_line, 0);
    chk({tag, "_busy"}, bad_busy, 0);
    chk({tag, "_early_done"}, bad_done, 0);
    chk({tag, "_done"}, tx_done, 1'b1);
    chk({tag, "_state_end"}, uart_state, 1'b0);
    chk({tag, "_tx_end"}, rs232_tx, 1'b1);
  endtask

  initial begin
    int bad;
    rst       = 1'b0;
    baud_set  = 3'd0;
    data_byte = 8'h00;
    send_en   = 1'b0;

    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rs232_tx !== 1'b1 || uart_state !== 1'b0
          || tx_done !== 1'b0) bad++;
    end
    chk("rst_hold", bad, 0);
    chk("rst_tx", rs232_tx, 1'b1);
    rst = 1'b1;
    idle("post_rst_idle", 10);

    start(8'hAA, 3'd4);
    watch("aa_b4", 8'hAA, 434, -1);
    idle("idle5k", 5000);

    start(8'h55, 3'd4);
    watch("55_b4", 8'h55, 434, -1);
    idle("idle_55", 20);

    // Mid-frame strobe with different byte/baud must be ignored.
    start(8'h0F, 3'd0);
    watch("0f_b0", 8'h0F, 5208, 3000);
    // Back-to-back: strobe in the tx_done cycle.
    start(8'h3C, 3'd7);
    chk("b2b_done_clr", tx_done, 1'b0);
    watch("3c_b7", 8'h3C, 434, -1);
    idle("idle_3c", 20);

    // Abort during data bit 3 (frame bit 4).
    start(8'h96, 3'd4);
    repeat (4 * 434 + 200) step();
    chk("abort_pre_tx", rs232_tx, 1'b0);
    rst = 1'b0;
    #1;
    chk("abort_tx", rs232_tx, 1'b1);
    chk("abort_state", uart_state, 1'b0);
    chk("abort_done", tx_done, 1'b0);
    step();
    step();
    rst = 1'b1;
    idle("abort_idle", 500);

    start(8'hC3, 3'd4);
    watch("c3_b4", 8'hC3, 434, -1);
    idle("idle_c3", 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
